div_mult_seq: RTL

//  Sequential signed MULT/DIV unit and its controller for the multicycle MIPS datapath.

---
 rtl/div_mult_seq.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/div_mult_seq.sv
// Sequential signed MULT (radix-2 Booth) / DIV (restoring) unit for the multicycle MIPS datapath.
// Optional `MULT_EARLY_TERM_EN: MULT finishes early once the remaining multiplier bits are all 0s or all 1s.
module div_mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} state_t;

  localparam int CW = $clog2(WIDTH) + 1;
  // One guard bit above the upper half keeps Booth add/sub of -2^(WIDTH-1) from overflowing.
  localparam int AW = 2 * WIDTH + 2;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [AW-1:0]    acc;
  logic             sign_a;
  logic             sign_b;
  logic             zero_flag;

  logic [WIDTH:0]   upper;
  logic [WIDTH:0]   upper_sum;
  logic [AW-1:0]    acc_step;
  logic [AW-1:0]    acc_next;
  logic             mult_last;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;

`ifdef MULT_EARLY_TERM_EN
  logic [CW-1:0]    remaining;
  logic [AW-1:0]    mask;
`endif

  always_comb begin
    upper = acc[AW-1:WIDTH+1];
    case (acc[1:0])
      2'b01:   upper_sum = upper + {mcand[WIDTH-1], mcand};
      2'b10:   upper_sum = upper - {mcand[WIDTH-1], mcand};
      default: upper_sum = upper;
    endcase
    acc_step  = $signed({upper_sum, acc[WIDTH:0]}) >>> 1;
    acc_next  = acc_step;
    mult_last = (count == LAST);
`ifdef MULT_EARLY_TERM_EN
    // Unconsumed multiplier bits plus q-1 sit in acc_step[remaining:0]; uniform bits mean no more add/sub.
    remaining = LAST - count;
    mask      = (AW'(1) << (remaining + CW'(1))) - AW'(1);
    if (!mult_last && (((acc_step & mask) == '0) || ((acc_step & mask) == mask))) begin
      acc_next  = $signed(acc_step) >>> remaining;
      mult_last = 1'b1;
    end
`endif
  end

  always_comb begin
    rem_shift = {rem, quo[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, divisor};
    a_abs     = a_in[WIDTH-1] ? -a_in : a_in;
    b_abs     = b_in[WIDTH-1] ? -b_in : b_in;
  end

  // Status outputs are registered from the state, so done/div_zero appear one cycle after DONE is entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      mcand     <= '0;
      divisor   <= '0;
      rem       <= '0;
      quo       <= '0;
      acc       <= '0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      zero_flag <= 1'b0;
      hi_out    <= '0;
      lo_out    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      busy     <= (state == MULT) || (state == DIV) || (state == FIX);
      done     <= (state == DONE);
      div_zero <= (state == DONE) && zero_flag;
      case (state)
        IDLE: begin
          if (start) begin
            count     <= '0;
            sign_a    <= a_in[WIDTH-1];
            sign_b    <= b_in[WIDTH-1];
            zero_flag <= 1'b0;
            if (!op) begin
              mcand <= a_in;
              acc   <= {{(WIDTH+1){1'b0}}, b_in, 1'b0};
              state <= MULT;
            end else if (b_in == '0) begin
              zero_flag <= 1'b1;
              state     <= DONE;
            end else begin
              divisor <= b_abs;
              quo     <= a_abs;
              rem     <= '0;
              state   <= DIV;
            end
          end
        end
        MULT: begin
          acc   <= acc_next;
          count <= count + 1'b1;
          if (mult_last) begin
            hi_out <= acc_next[2*WIDTH:WIDTH+1];
            lo_out <= acc_next[WIDTH:1];
            state  <= DONE;
          end
        end
        DIV: begin
          count <= count + 1'b1;
          if (rem_diff[WIDTH]) begin
            rem <= rem_shift[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end else begin
            rem <= rem_diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end
          if (count == LAST) begin
            state <= FIX;
          end
        end
        FIX: begin
          // Quotient truncates toward zero; remainder follows the dividend's sign.
          lo_out <= (sign_a ^ sign_b) ? -quo : quo;
          hi_out <= sign_a ? -rem : rem;
          state  <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
